// File: rtl/iq_stream_serializer_if.sv
// iq_stream_serializer_if
// Parallel I/Q capture side and serialized stream side of the I/Q serializer.
// The master drives samples and the overrun clear; the slave (the serializer)
// returns the handshake, the serialized word stream and the overrun flag.
interface iq_stream_serializer_if #(
  parameter int DW   = 21,
  parameter int N_CH = 4
);
  logic                 strobe_in;
  logic [N_CH*DW-1:0]   i_in;
  logic [N_CH*DW-1:0]   q_in;
  logic                 ready;
  logic [DW-1:0]        stream_out;
  logic                 strobe_out;
  logic                 frame_out;
  logic                 overrun;
  logic                 clr_overrun;

  modport master (
    output strobe_in, i_in, q_in, clr_overrun,
    input  ready, stream_out, strobe_out, frame_out, overrun
  );

  modport slave (
    input  strobe_in, i_in, q_in, clr_overrun,
    output ready, stream_out, strobe_out, frame_out, overrun
  );
endinterface

// File: rtl/iq_stream_serializer.sv
// iq_stream_serializer
// Captures N_CH parallel I/Q pairs on strobe_in and emits them one word per
// clock (ch0 I, ch0 Q, ch1 I, ... ch(N_CH-1) Q) with strobe_out/frame_out.
// A frame is followed by GAP idle cycles before the next one may start.
// Optional feature macro: IQ_SER_DBUF_EN adds a one-entry holding buffer so a
// strobe arriving while busy is queued instead of dropped.
module iq_stream_serializer #(
  parameter int DW   = 21,
  parameter int N_CH = 4,
  parameter int GAP  = 0
) (
  input  logic                  sample_clk,
  input  logic                  sample_rst_n,
  iq_stream_serializer_if.slave bus
);

  localparam int NW = 2 * N_CH;
  localparam int PW = N_CH * DW;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(NW - 1);
  localparam logic [GW-1:0] GAP_LAST  = (GAP > 0) ? GW'(GAP - 1) : {GW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   word_cnt_r;
  logic [GW-1:0]   gap_cnt_r;
  logic [PW-1:0]   cap_i_r;
  logic [PW-1:0]   cap_q_r;
  logic [DW-1:0]   stream_out_r;
  logic            strobe_out_r;
  logic            frame_out_r;
  logic            overrun_r;

  logic            last_word_s;
  logic            gap_last_s;
  logic            launch_s;
  logic            ready_s;
  logic            start_s;
  logic [PW-1:0]   start_i_s;
  logic [PW-1:0]   start_q_s;
  logic            overrun_evt_s;
  logic [CW-1:0]   next_idx_s;
  logic [DW-1:0]   next_word_s;

`ifdef IQ_SER_DBUF_EN
  logic            buf_valid_r;
  logic [PW-1:0]   buf_i_r;
  logic [PW-1:0]   buf_q_r;
  logic            buf_load_s;
  logic            buf_drain_s;
`endif

  // Word at position idx of the frame: even positions are I, odd are Q.
  function automatic logic [DW-1:0] select_word(
    input logic [PW-1:0] iv,
    input logic [PW-1:0] qv,
    input logic [CW-1:0] idx
  );
    logic [DW-1:0] w;
    w = {DW{1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      if (idx == CW'(2 * k)) begin
        w = iv[k*DW +: DW];
      end else if (idx == CW'(2 * k + 1)) begin
        w = qv[k*DW +: DW];
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // Launch points, handshake, frame start source and the next word to emit.
  always_comb begin
    ready_s       = 1'b0;
    start_s       = 1'b0;
    start_i_s     = bus.i_in;
    start_q_s     = bus.q_in;
`ifdef IQ_SER_DBUF_EN
    buf_load_s    = 1'b0;
    buf_drain_s   = 1'b0;
`endif
    last_word_s   = (state_r == ST_SEND) && (word_cnt_r == LAST_WORD);
    gap_last_s    = (state_r == ST_GAP) && (gap_cnt_r == GAP_LAST);
    // A new frame may start in IDLE or on the cycle the previous frame ends.
    if (GAP == 0) begin
      launch_s = (state_r == ST_IDLE) || last_word_s;
    end else begin
      launch_s = (state_r == ST_IDLE) || gap_last_s;
    end
`ifdef IQ_SER_DBUF_EN
    ready_s = !buf_valid_r || (state_r == ST_IDLE);
    if (launch_s && buf_valid_r) begin
      start_s     = 1'b1;
      start_i_s   = buf_i_r;
      start_q_s   = buf_q_r;
      buf_drain_s = 1'b1;
    end else if (launch_s && bus.strobe_in) begin
      start_s     = 1'b1;
    end else begin
      start_s     = 1'b0;
    end
    buf_load_s = bus.strobe_in && !buf_valid_r && !launch_s;
`else
    ready_s = launch_s;
    start_s = launch_s && bus.strobe_in;
`endif
    overrun_evt_s = bus.strobe_in && !ready_s;
    next_idx_s    = word_cnt_r + CW'(1);
    next_word_s   = select_word(cap_i_r, cap_q_r, next_idx_s);
  end

  // Frame sequencer: capture, word emission, inter-frame gap and overrun flag.
  always_ff @(posedge sample_clk or negedge sample_rst_n) begin
    if (!sample_rst_n) begin
      state_r      <= ST_IDLE;
      word_cnt_r   <= {CW{1'b0}};
      gap_cnt_r    <= {GW{1'b0}};
      cap_i_r      <= {PW{1'b0}};
      cap_q_r      <= {PW{1'b0}};
      stream_out_r <= {DW{1'b0}};
      strobe_out_r <= 1'b0;
      frame_out_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      // Set wins over clear when both happen in the same cycle.
      if (overrun_evt_s) begin
        overrun_r <= 1'b1;
      end else if (bus.clr_overrun) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end

      if (start_s) begin
        cap_i_r      <= start_i_s;
        cap_q_r      <= start_q_s;
        state_r      <= ST_SEND;
        word_cnt_r   <= {CW{1'b0}};
        gap_cnt_r    <= {GW{1'b0}};
        stream_out_r <= start_i_s[DW-1:0];
        strobe_out_r <= 1'b1;
        frame_out_r  <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            strobe_out_r <= 1'b0;
            frame_out_r  <= 1'b0;
          end
          ST_SEND: begin
            frame_out_r <= 1'b0;
            if (last_word_s) begin
              strobe_out_r <= 1'b0;
              gap_cnt_r    <= {GW{1'b0}};
              if (GAP > 0) begin
                state_r <= ST_GAP;
              end else begin
                state_r <= ST_IDLE;
              end
            end else begin
              word_cnt_r   <= next_idx_s;
              stream_out_r <= next_word_s;
              strobe_out_r <= 1'b1;
            end
          end
          ST_GAP: begin
            strobe_out_r <= 1'b0;
            frame_out_r  <= 1'b0;
            if (gap_last_s) begin
              state_r <= ST_IDLE;
            end else begin
              gap_cnt_r <= gap_cnt_r + GW'(1);
            end
          end
          default: begin
            state_r      <= ST_IDLE;
            strobe_out_r <= 1'b0;
            frame_out_r  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef IQ_SER_DBUF_EN
  // Holding buffer: stores one strobe that arrived while busy, drains at launch.
  always_ff @(posedge sample_clk or negedge sample_rst_n) begin
    if (!sample_rst_n) begin
      buf_valid_r <= 1'b0;
      buf_i_r     <= {PW{1'b0}};
      buf_q_r     <= {PW{1'b0}};
    end else if (buf_load_s) begin
      buf_valid_r <= 1'b1;
      buf_i_r     <= bus.i_in;
      buf_q_r     <= bus.q_in;
    end else if (buf_drain_s) begin
      buf_valid_r <= 1'b0;
    end else begin
      buf_valid_r <= buf_valid_r;
    end
  end
`endif

  assign bus.ready      = ready_s;
  assign bus.stream_out = stream_out_r;
  assign bus.strobe_out = strobe_out_r;
  assign bus.frame_out  = frame_out_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_iq_stream_serializer.sv
// tb_iq_stream_serializer
// Two serializers (GAP=0 and GAP=3) share one clock and reset. A frame-level
// reference model schedules expected words per cycle from the acceptance
// rules and every output is compared each cycle.
module tb_iq_stream_serializer;

  localparam int DW    = 21;
  localparam int N_CH  = 4;
  localparam int NW    = 2 * N_CH;
  localparam int PW    = N_CH * DW;
  localparam int GAP_A = 0;
  localparam int GAP_B = 3;
  localparam int KEY_STRIDE = 1000000;
`ifdef IQ_SER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic sample_clk = 1'b0;
  logic sample_rst_n = 1'b0;
  int   cyc = 0;

  always #5 sample_clk = ~sample_clk;

  // Cycle index: outputs registered at edge k are visible during cycle k.
  always @(posedge sample_clk) cyc <= cyc + 1;

  logic          strobe_t  [2];
  logic          clr_t     [2];
  logic [PW-1:0] i_t       [2];
  logic [PW-1:0] q_t       [2];
  logic          ready_t   [2];
  logic [DW-1:0] word_t    [2];
  logic          sout_t    [2];
  logic          fout_t    [2];
  logic          ovr_t     [2];

  iq_stream_serializer_if #(.DW(DW), .N_CH(N_CH)) bus_a ();
  iq_stream_serializer_if #(.DW(DW), .N_CH(N_CH)) bus_b ();

  iq_stream_serializer #(.DW(DW), .N_CH(N_CH), .GAP(GAP_A)) dut_a (
    .sample_clk   (sample_clk),
    .sample_rst_n (sample_rst_n),
    .bus          (bus_a.slave)
  );

  iq_stream_serializer #(.DW(DW), .N_CH(N_CH), .GAP(GAP_B)) dut_b (
    .sample_clk   (sample_clk),
    .sample_rst_n (sample_rst_n),
    .bus          (bus_b.slave)
  );

  assign bus_a.strobe_in   = strobe_t[0];
  assign bus_a.clr_overrun = clr_t[0];
  assign bus_a.i_in        = i_t[0];
  assign bus_a.q_in        = q_t[0];
  assign bus_b.strobe_in   = strobe_t[1];
  assign bus_b.clr_overrun = clr_t[1];
  assign bus_b.i_in        = i_t[1];
  assign bus_b.q_in        = q_t[1];

  assign ready_t[0] = bus_a.ready;
  assign word_t[0]  = bus_a.stream_out;
  assign sout_t[0]  = bus_a.strobe_out;
  assign fout_t[0]  = bus_a.frame_out;
  assign ovr_t[0]   = bus_a.overrun;
  assign ready_t[1] = bus_b.ready;
  assign word_t[1]  = bus_b.stream_out;
  assign sout_t[1]  = bus_b.strobe_out;
  assign fout_t[1]  = bus_b.frame_out;
  assign ovr_t[1]   = bus_b.overrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (per DUT)
  int            gap_of     [2];
  int            next_ok    [2];
  int            last_start [2];
  logic [DW-1:0] last_word  [2];
  bit            exp_ov     [2];
  logic [DW-1:0] sched_word  [int];
  bit            sched_first [int];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sched_word.delete();
    sched_first.delete();
    for (int d = 0; d < 2; d++) begin
      next_ok[d]    = 0;
      last_start[d] = -KEY_STRIDE;
      last_word[d]  = '0;
      exp_ov[d]     = 1'b0;
    end
  endtask

  function automatic bit exp_ready(input int d, input int c);
    if (DBUF) return !(last_start[d] >= c);
    return c >= next_ok[d];
  endfunction

  // Frame-level acceptance: returns 1 when the strobe is an overrun event.
  task automatic model_strobe(input int d, input int c, input logic [PW-1:0] iv,
                              input logic [PW-1:0] qv, output bit ovr);
    int start;
    bit ok;
    ok = 1'b1;
    start = c;
    if (c >= next_ok[d]) start = c;
    else if (DBUF && last_start[d] < c) start = next_ok[d];
    else ok = 1'b0;
    if (ok) begin
      for (int w = 0; w < NW; w++) begin
        int ch;
        int key;
        ch  = w / 2;
        key = d * KEY_STRIDE + start + 1 + w;
        sched_word[key]  = (w % 2 == 0) ? iv[ch*DW +: DW] : qv[ch*DW +: DW];
        sched_first[key] = (w == 0);
      end
      last_start[d] = start;
      next_ok[d]    = start + NW + gap_of[d];
    end
    ovr = !ok;
  endtask

  task automatic check_outputs(input int d);
    int key;
    logic [DW-1:0] ew;
    bit es;
    bit ef;
    key = d * KEY_STRIDE + cyc;
    if (sched_word.exists(key)) begin
      es = 1'b1;
      ew = sched_word[key];
      ef = sched_first[key];
      last_word[d] = ew;
    end else begin
      es = 1'b0;
      ew = last_word[d];
      ef = 1'b0;
    end
    check_val($sformatf("strobe_out[%0d]", d), 64'(sout_t[d]), 64'(es));
    check_val($sformatf("stream_out[%0d]", d), 64'(word_t[d]), 64'(ew));
    check_val($sformatf("frame_out[%0d]", d), 64'(fout_t[d]), 64'(ef));
    check_val($sformatf("overrun[%0d]", d), 64'(ovr_t[d]), 64'(exp_ov[d]));
  endtask

  // One clock: check ready, feed the model, advance, check registered outputs.
  task automatic tick();
    bit ev [2];
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("ready[%0d]", d), 64'(ready_t[d]), 64'(exp_ready(d, cyc)));
      ev[d] = 1'b0;
      if (strobe_t[d]) model_strobe(d, cyc, i_t[d], q_t[d], ev[d]);
    end
    @(posedge sample_clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_ov[d] = ev[d] ? 1'b1 : (clr_t[d] ? 1'b0 : exp_ov[d]);
      check_outputs(d);
    end
  endtask

  task automatic set_strobe(input bit s);
    strobe_t[0] = s;
    strobe_t[1] = s;
  endtask

  task automatic set_clr(input bit s);
    clr_t[0] = s;
    clr_t[1] = s;
  endtask

  task automatic set_pattern(input int base_i, input int base_q);
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < N_CH; k++) begin
        i_t[d][k*DW +: DW] = DW'(base_i + k);
        q_t[d][k*DW +: DW] = DW'(-(base_q + k));
      end
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 21'h0FFFFF;
      1: return 21'h100001;
      2: return 21'h100000;
      3: return 21'h000000;
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic randomize_data();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < N_CH; k++) begin
        i_t[d][k*DW +: DW] = rand_word();
        q_t[d][k*DW +: DW] = rand_word();
      end
    end
  endtask

  initial begin
    gap_of[0] = GAP_A;
    gap_of[1] = GAP_B;
    set_strobe(1'b0);
    set_clr(1'b0);
    set_pattern(0, 0);
    model_reset();
    sample_rst_n = 1'b0;

    // Reset state
    repeat (3) @(posedge sample_clk);
    #1;
    for (int d = 0; d < 2; d++) check_outputs(d);
    @(negedge sample_clk);
    sample_rst_n = 1'b1;
    tick();

    // Single frame: I = 100+k, Q = -(200+k)
    set_pattern(100, 200);
    set_strobe(1'b1);
    tick();
    set_strobe(1'b0);
    repeat (12) tick();

    // Back-to-back: second strobe eight cycles later with ch0 I = 7
    set_strobe(1'b1);
    tick();
    set_strobe(1'b0);
    repeat (7) tick();
    i_t[0][DW-1:0] = DW'(7);
    i_t[1][DW-1:0] = DW'(7);
    set_strobe(1'b1);
    tick();
    set_strobe(1'b0);
    repeat (14) tick();

    // Strobes at t and t+4, then clear overrun
    set_pattern(300, 400);
    set_strobe(1'b1);
    tick();
    set_strobe(1'b0);
    repeat (3) tick();
    set_pattern(500, 600);
    set_strobe(1'b1);
    tick();
    set_strobe(1'b0);
    repeat (24) tick();
    set_clr(1'b1);
    tick();
    set_clr(1'b0);
    tick();

    // Overrun event and clear in the same cycle
    set_strobe(1'b1);
    tick();
    set_strobe(1'b0);
    tick();
    set_strobe(1'b1);
    tick();
    set_clr(1'b1);
    tick();
    set_strobe(1'b0);
    tick();
    set_clr(1'b0);
    repeat (24) tick();
    set_clr(1'b1);
    tick();
    set_clr(1'b0);

    // Data freeze: inputs change every cycle while the frame is sent
    set_pattern(700, 800);
    set_strobe(1'b1);
    tick();
    set_strobe(1'b0);
    for (int n = 0; n < 12; n++) begin
      randomize_data();
      tick();
    end

    // Reset asserted while word 3 is on the bus
    set_pattern(900, 1000);
    set_strobe(1'b1);
    tick();
    set_strobe(1'b0);
    repeat (3) tick();
    #1;
    sample_rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      check_outputs(d);
      check_val($sformatf("ready_in_reset[%0d]", d), 64'(ready_t[d]), 64'(1));
    end
    repeat (2) @(posedge sample_clk);
    @(negedge sample_clk);
    sample_rst_n = 1'b1;
    set_pattern(1100, 1200);
    set_strobe(1'b1);
    tick();
    set_strobe(1'b0);
    repeat (12) tick();

    // Randomized traffic with boundary values
    for (int n = 0; n < 3000; n++) begin
      randomize_data();
      strobe_t[0] = ($urandom_range(0, 3) == 0);
      strobe_t[1] = ($urandom_range(0, 3) == 0);
      clr_t[0]    = ($urandom_range(0, 15) == 0);
      clr_t[1]    = ($urandom_range(0, 15) == 0);
      tick();
    end
    set_strobe(1'b0);
    set_clr(1'b0);
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iq_stream_serializer.md
Name: iq_stream_serializer

Overview:
- Writer end of the time-multiplexed I/Q stream consumed by grab_channels.
- Captures N_CH parallel I/Q pairs on a sample strobe and emits them one word per clock on a single DW-wide bus, with a qualifying strobe.
- Used to feed the post-DDC channel deserializer and host readout from parallel per-channel results, and to generate deterministic stimulus streams.

Parameters:
- DW, 21, word width of each I or Q value (two's complement).
- N_CH, 4, number of channels per frame; the frame is 2*N_CH words.
- GAP, 0, minimum idle cycles with strobe_out low between consecutive frames.

Ports:
- sample_clk  input  1  sample clock; all logic on rising edge.
- sample_rst_n  input  1  asynchronous active-low reset.
- strobe_in  input  1  one-cycle pulse; i_in/q_in valid and captured when ready is high.
- i_in  input  N_CH*DW  packed I values, channel k at bits [k*DW +: DW].
- q_in  input  N_CH*DW  packed Q values, same packing.
- ready  output  1  combinational; strobe_in is accepted this cycle.
- stream_out  output  DW  serialized word.
- strobe_out  output  1  stream_out valid.
- frame_out  output  1  high with the first word (ch0 I) of each frame.
- overrun  output  1  sticky; a strobe_in arrived while ready was low.
- clr_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset (async assert, sync release): state IDLE, word counter 0, gap counter 0. stream_out=0, strobe_out=0, frame_out=0, overrun=0. Capture registers cleared.
- Word order: ch0 I, ch0 Q, ch1 I, ch1 Q, …, ch(N_CH-1) Q.
- States:
  - IDLE: ready=1. On strobe_in, capture i_in/q_in and go to SEND with word counter 0.
  - SEND: one word per cycle. Registered outputs, so the first word appears the cycle after capture (latency 1). strobe_out is high for exactly 2*N_CH consecutive cycles.
  - After the last word: go to GAP if GAP>0, else IDLE.
  - GAP: strobe_out=0 for GAP cycles, then IDLE.
- ready:
  - High in IDLE.
  - Also high in the cycle the last word is being registered out when GAP=0. An accepted strobe_in there starts the next frame back-to-back with no idle cycle.
  - Also high in the final GAP cycle.
- Captured data is frozen for the whole frame. Changes on i_in/q_in after capture must not affect the words in flight.
- strobe_in with ready low: data is dropped and overrun is set the next cycle. The current frame continues unaffected.
- clr_overrun together with a new overrun event in the same cycle: overrun stays 1 (set wins).
- stream_out holds its last value when strobe_out=0; downstream must qualify with strobe_out.
- Reset asserted mid-frame: outputs return to reset values immediately (async). The partial frame is abandoned; after release the block resumes at IDLE.
- No arithmetic is applied; values pass bit-exact.

Optional Feature:
- Macro: IQ_SER_DBUF_EN.
- When defined:
  - A one-entry holding buffer sits in front of the capture registers.
  - A strobe_in while busy and the buffer is empty is stored, and that frame starts at the next point where ready would be high. Resulting spacing: back-to-back if GAP=0, else exactly GAP idle cycles.
  - ready then means "buffer empty or IDLE". overrun is set only when strobe_in arrives with the buffer full; that data is dropped.
  - Buffered data is cleared by reset.
- When undefined: no buffer; behaviour as above.

Test Plan:
- Single frame: N_CH=4, i_in ch k = 100+k, q_in ch k = -(200+k), one strobe_in at cycle t. Expect strobe_out high cycles t+1..t+8, stream_out = 100,-200,101,-201,102,-202,103,-203, frame_out only at t+1, overrun=0.
- Back-to-back: GAP=0, second strobe_in at t+8 with ch0 I=7. Expect 16 consecutive strobe_out cycles, word 9 = 7, frame_out at t+1 and t+9.
- Gap and overrun: GAP=3, strobes at t and t+4. Without DBUF: second frame dropped, overrun=1 from t+5, clr_overrun clears it. With IQ_SER_DBUF_EN: second frame starts at t+12, overrun=0.
- Data freeze: change i_in every cycle during SEND. Expect emitted words to equal only the values present at the capture cycle.
- Reset mid-frame: assert sample_rst_n=0 at word 3 of a frame. Expect strobe_out=0, stream_out=0 immediately. After release, a new strobe_in yields a complete correct frame.
- Round trip: serializer into grab_channels with DW=21 and random signed values incl. ±(2^20-1) and -2^20. Expect recovered i_out0/q_out0 to match inputs bit-exact for 1000 frames.
